// File: rtl/memory_access_unit.sv
// memory_access_unit: M-stage load/store engine over a req/ack bus (clk, rst, pipeline in, StallM/ReadDataM/MisalignM/BusErrM out, mem_* bus)
module memory_access_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MemReadM,
  input  logic                  MemWriteM,
  input  logic [2:0]            funct3M,
  input  logic [DATA_WIDTH-1:0] ALUResultM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  output logic                  StallM,
  output logic [DATA_WIDTH-1:0] ReadDataM,
  output logic                  MisalignM,
  output logic                  BusErrM,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_be,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [2:0] f3;
  logic [1:0] a_lo;
  logic ld, st, legal, start, timeout;
  logic [3:0] be_n;
  logic [DATA_WIDTH-1:0] wdata_n, rdata_fmt;
  logic [7:0] lb;
  logic [15:0] lh;
  always_comb begin
    ld = MemReadM & ~MemWriteM;
    st = MemWriteM & ~MemReadM;
    legal = (ld | st) & (funct3M[1:0] == 2'b00 ? (ld | ~funct3M[2]) :
                         funct3M[1:0] == 2'b01 ? (ld | ~funct3M[2]) & ~ALUResultM[0] :
                         funct3M == 3'b010     ? ALUResultM[1:0] == 2'b00 : 1'b0);
    start = state == IDLE & (MemReadM | MemWriteM) & legal;
    timeout = TIMEOUT != 0 && !mem_ack && cnt >= CW'(TIMEOUT - 1);
    state_n = state == IDLE ? (start ? REQ : IDLE) :
              state == REQ  ? ((mem_ack | timeout) ? DONE : REQ) : IDLE;
    StallM = ~rst & (start | state == REQ);
    MisalignM = ~rst & state == IDLE & (MemReadM | MemWriteM) & ~legal;
    mem_req = state == REQ;
    be_n = MemWriteM ? (funct3M[1] ? 4'hF : (funct3M[0] ? 4'b0011 : 4'b0001) << ALUResultM[1:0]) : 4'hF;
    wdata_n = funct3M[1] ? WriteDataM : funct3M[0] ? {2{WriteDataM[15:0]}} : {4{WriteDataM[7:0]}};
    lb = mem_rdata[{a_lo, 3'b000} +: 8];
    lh = a_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    rdata_fmt = f3[1] ? mem_rdata : f3[0] ? {{16{~f3[2] & lh[15]}}, lh} : {{24{~f3[2] & lb[7]}}, lb};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      f3 <= '0;
      a_lo <= '0;
      mem_we <= 1'b0;
      mem_be <= '0;
      mem_addr <= '0;
      mem_wdata <= '0;
      ReadDataM <= '0;
      BusErrM <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= state == REQ ? (&cnt ? cnt : cnt + CW'(1)) : '0;
      BusErrM <= state == REQ & timeout;
      if (start) begin
        f3 <= funct3M;
        a_lo <= ALUResultM[1:0];
        mem_we <= MemWriteM;
        mem_be <= be_n;
        mem_addr <= {ALUResultM[DATA_WIDTH-1:2], 2'b00};
        mem_wdata <= wdata_n;
      end
      if (state == REQ & (mem_ack | timeout))
        ReadDataM <= mem_ack & ~mem_we ? rdata_fmt : '0;
    end
  end
endmodule

// File: tb/tb_memory_access_unit.sv
// tb_memory_access_unit: scoreboard bench for memory_access_unit
module tb_memory_access_unit;
  localparam int TO = 4;
  logic clk = 0, rst = 1;
  logic MemReadM = 0, MemWriteM = 0, mem_ack = 0;
  logic [2:0] funct3M = 0;
  logic [31:0] ALUResultM = 0, WriteDataM = 0, mem_rdata = 0;
  logic StallM, MisalignM, BusErrM, mem_req, mem_we;
  logic [31:0] ReadDataM, mem_addr, mem_wdata;
  logic [3:0] mem_be;
  int n_chk = 0, n_fail = 0;
  logic [32:0] sb[$];
  logic prev_req = 0;
  memory_access_unit #(.DATA_WIDTH(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .MemReadM(MemReadM), .MemWriteM(MemWriteM), .funct3M(funct3M),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .StallM(StallM), .ReadDataM(ReadDataM),
    .MisalignM(MisalignM), .BusErrM(BusErrM), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] addr, input logic [31:0] rd);
    logic [31:0] b, h;
    b = rd >> (8 * addr[1:0]);
    h = rd >> (16 * addr[1]);
    case (f)
      3'b000: return 32'($signed(b[7:0]));
      3'b001: return 32'($signed(h[15:0]));
      3'b100: return b & 32'hFF;
      3'b101: return h & 32'hFFFF;
      default: return rd;
    endcase
  endfunction
  always @(negedge clk) begin
    logic [32:0] e;
    if (!rst && prev_req && !mem_req) begin
      check("sb_pending", 32'(sb.size()), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("ReadDataM", ReadDataM, e[32:1]);
        check("BusErrM", {31'b0, BusErrM}, {31'b0, e[0]});
      end
    end
    prev_req = rst ? 1'b0 : mem_req;
  end
  task automatic access(input logic rd, input logic wr, input logic [2:0] f, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rdv, input int dly,
                        input logic [3:0] ebe, input logic [31:0] ewd);
    logic acked;
    MemReadM = rd; MemWriteM = wr; funct3M = f; ALUResultM = addr; WriteDataM = wd; mem_rdata = rdv;
    @(negedge clk);
    check("stall_idle", StallM, 1);
    check("misalign_legal", MisalignM, 0);
    sb.push_back(dly >= TO ? {32'h0, 1'b1} : {wr ? 32'h0 : model(f, addr, rdv), 1'b0});
    @(posedge clk); #1 MemReadM = 0; MemWriteM = 0;
    for (int n = 0; n < TO; n++) begin
      @(negedge clk);
      check("req", mem_req, 1);
      check("stall_req", StallM, 1);
      check("buserr_req", BusErrM, 0);
      if (n == 0) begin
        check("addr", mem_addr, {addr[31:2], 2'b00});
        check("we", mem_we, wr);
        check("be", mem_be, ebe);
        if (wr) check("wdata", mem_wdata, ewd);
      end
      acked = n == dly;
      if (acked) mem_ack = 1;
      @(posedge clk); #1 mem_ack = 0;
      if (acked) break;
    end
    @(negedge clk);
    check("stall_done", StallM, 0);
    check("req_done", mem_req, 0);
    @(posedge clk); #1;
  endtask
  task automatic bad(input logic rd, input logic wr, input logic [2:0] f, input logic [31:0] addr);
    MemReadM = rd; MemWriteM = wr; funct3M = f; ALUResultM = addr;
    @(negedge clk);
    check("misalign", MisalignM, 1);
    check("stall_bad", StallM, 0);
    check("req_bad", mem_req, 0);
    @(posedge clk); #1 MemReadM = 0; MemWriteM = 0;
    @(negedge clk);
    check("misalign_end", MisalignM, 0);
    check("req_after_bad", mem_req, 0);
    @(posedge clk); #1;
  endtask
  initial begin
    #100000 $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("rst_stall", StallM, 0);
    check("rst_req", mem_req, 0);
    check("rst_rdata", ReadDataM, 0);
    check("rst_be", mem_be, 0);
    @(posedge clk); #1;
    access(1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0, 4'hF, 0);
    access(1, 0, 3'b000, 32'h103, 0, 32'h80FFFF7F, 1, 4'hF, 0);
    access(1, 0, 3'b100, 32'h103, 0, 32'h80FFFF7F, 0, 4'hF, 0);
    access(0, 1, 3'b001, 32'h22, 32'h1234ABCD, 32'h5555AAAA, 2, 4'b1100, 32'hABCDABCD);
    access(0, 1, 3'b000, 32'h101, 32'h00000055, 0, 0, 4'b0010, 32'h55555555);
    access(0, 1, 3'b010, 32'h40, 32'hCAFEF00D, 0, 1, 4'hF, 32'hCAFEF00D);
    access(1, 0, 3'b001, 32'h202, 0, 32'h80011234, 0, 4'hF, 0);
    access(1, 0, 3'b101, 32'h200, 0, 32'h8001F234, 0, 4'hF, 0);
    access(1, 0, 3'b010, 32'h300, 0, 32'h11112222, 10, 4'hF, 0);
    access(1, 0, 3'b010, 32'h304, 0, 32'h0BADF00D, TO - 1, 4'hF, 0);
    bad(1, 0, 3'b010, 32'h102);
    bad(1, 0, 3'b001, 32'h101);
    bad(0, 1, 3'b010, 32'h2);
    bad(1, 0, 3'b011, 32'h0);
    bad(0, 1, 3'b100, 32'h0);
    bad(1, 1, 3'b000, 32'h0);
    check("rdata_hold", ReadDataM, 32'h0BADF00D);
    MemReadM = 1; funct3M = 3'b010; ALUResultM = 32'h400;
    @(posedge clk); #1 MemReadM = 0;
    @(negedge clk);
    check("abort_req1", mem_req, 1);
    @(posedge clk); #1 rst = 1;
    @(negedge clk);
    check("abort_stall_rst", StallM, 0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    check("abort_req", mem_req, 0);
    check("abort_stall", StallM, 0);
    check("abort_rdata", ReadDataM, 0);
    check("abort_buserr", BusErrM, 0);
    check("abort_be", mem_be, 0);
    check("abort_addr", mem_addr, 0);
    check("abort_we", mem_we, 0);
    repeat (2) @(negedge clk);
    check("abort_idle_req", mem_req, 0);
    check("sb_drained", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
